// File: rtl/uart_tx_fifo_drive.sv
// uart_tx_fifo_drive
//   Buffered UART transmitter. Words arriving on a valid/ready stream are
//   queued in a FIFO and serialised onto o_uart_tx back-to-back: when the last
//   stop-bit clock of a frame sees another word waiting, the next start bit
//   follows with no idle gap.
//
//   Ports
//     i_clk            system clock (single domain)
//     i_rst            synchronous, active-high reset
//     i_user_tx_data   word to send (P_UART_DATA_WIDTH bits)
//     i_user_tx_valid  word present
//     o_user_tx_ready  registered; FIFO can accept a word this cycle
//     o_uart_tx        serial line, idle high
//     o_tx_busy        high while a frame is in progress
//     o_fifo_level     words held in the FIFO (excludes the word in flight)
//     i_break          only with UART_TX_BREAK_EN: hold the line low while idle
//
//   Optional feature macro: UART_TX_BREAK_EN (line break generation).
//
//   Timing: the line is a register fed from the current FSM state, so the
//   serial waveform trails the state (and o_tx_busy) by exactly one clock.
//   A handshake at edge N with an idle, empty transmitter pops at N+1 and
//   drives the start bit after N+2.
module uart_tx_fifo_drive #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BAUDRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0]     i_user_tx_data,
  input  logic                             i_user_tx_valid,
  output logic                             o_user_tx_ready,
  output logic                             o_uart_tx,
  output logic                             o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]    o_fifo_level
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                             i_break
`endif
);

  localparam int P_DIV  = P_SYSTEM_CLK / P_UART_BAUDRATE;
  localparam int DW     = P_UART_DATA_WIDTH;
  localparam int ADDR_W = $clog2(P_FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int CNT_W  = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam int BIT_W  = $clog2(DW + 1);
  localparam bit HAS_PARITY = (P_UART_CHECK != 0);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(P_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DW - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DW-1:0]     fifo_mem [P_FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  level_next;
  logic              ready_reg;
  logic              push;
  logic              pop;
  logic              can_pop;
  logic [DW-1:0]     fifo_head;

  // ready_reg is only high when level_reg < depth, so push never overfills.
  assign push      = i_user_tx_valid & ready_reg;
  assign fifo_head = fifo_mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (!push && pop) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  // Storage has no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= i_user_tx_data;
    end
  end

  // ---------------------------------------------------------------- break
`ifdef UART_TX_BREAK_EN
  // After break is released the line must sit at mark for one full bit time
  // before a start bit; guard_reg counts that interval down.
  logic [CNT_W-1:0] guard_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      guard_reg <= '0;
    end else if (i_break) begin
      guard_reg <= BAUD_LAST;
    end else if (guard_reg != '0) begin
      guard_reg <= guard_reg - CNT_W'(1);
    end
  end

  assign can_pop = (level_reg != '0) && !i_break && (guard_reg == '0);
`else
  assign can_pop = (level_reg != '0);
`endif

  // ---------------------------------------------------------------- FSM
  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg,  bit_cnt_next;
  logic [DW-1:0]    shift_reg,    shift_next;
  logic             parity_reg,   parity_next;
  logic             tx_reg,       line_next;
  logic             busy_reg;
  logic             bit_done;
  logic [CNT_W-1:0] baud_inc;

  function automatic logic parity_of(input logic [DW-1:0] d);
    // Odd: total ones including parity is odd; even: total is even.
    if (P_UART_CHECK == 1) begin
      return ~^d;
    end
    return ^d;
  endfunction

  assign bit_done = (baud_cnt_reg == BAUD_LAST);
  assign baud_inc = bit_done ? '0 : baud_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (can_pop) begin
          pop           = 1'b1;
          shift_next    = fifo_head;
          parity_next   = parity_of(fifo_head);
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        baud_cnt_next = baud_inc;
        if (bit_done) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_cnt_next = baud_inc;
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        baud_cnt_next = baud_inc;
        if (bit_done) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        baud_cnt_next = baud_inc;
        if (bit_done) begin
          if (bit_cnt_reg == STOP_LAST) begin
            bit_cnt_next = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (can_pop) begin
              pop         = 1'b1;
              shift_next  = fifo_head;
              parity_next = parity_of(fifo_head);
              state_next  = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    line_next = 1'b1;
    case (state_reg)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift_reg[0];
      ST_PARITY: line_next = parity_reg;
      default:   line_next = 1'b1;
    endcase
`ifdef UART_TX_BREAK_EN
    if (state_reg == ST_IDLE && i_break) begin
      line_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= line_next;
      busy_reg     <= (state_next != ST_IDLE);
      level_reg    <= level_next;
      ready_reg    <= (level_next < LVL_W'(P_FIFO_DEPTH));
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
    end
  end

  assign o_user_tx_ready = ready_reg;
  assign o_uart_tx       = tx_reg;
  assign o_tx_busy       = busy_reg;
  assign o_fifo_level    = level_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drive.sv
// Bench for uart_tx_fifo_drive: even parity, 1 stop bit, 8 data bits,
// 16-entry FIFO, bit time of 5 clocks. Stimulus pushes expected 11-bit frames
// (bit 0 = start, bits 8:1 = data LSB first, bit 9 = parity, bit 10 = stop)
// into a queue; an independent line monitor decodes frames and compares.
module tb_uart_tx_fifo_drive;

  localparam int DIV        = 5;
  localparam int FRAME_CLKS = 11 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [4:0] level;

  always #5 clk = ~clk;

  uart_tx_fifo_drive #(
    .P_SYSTEM_CLK      (50),
    .P_UART_BAUDRATE   (10),
    .P_UART_DATA_WIDTH (8),
    .P_UART_STOP_WIDTH (1),
    .P_UART_CHECK      (2),
    .P_FIFO_DEPTH      (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_user_tx_data  (data),
    .i_user_tx_valid (valid),
    .o_user_tx_ready (ready),
    .o_uart_tx       (tx),
    .o_tx_busy       (busy),
    .o_fifo_level    (level)
`ifdef UART_TX_BREAK_EN
    ,
    .i_break         (1'b0)
`endif
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          frames_seen = 0;
  logic [10:0] exp_q [$];

  // Cycle counter and busy span tracker (main resets busy_first to -1).
  int cyc        = 0;
  int busy_first = -1;
  int busy_last  = -1;

  always @(negedge clk) begin
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Even-parity frame model for the streamed words.
  function automatic logic [10:0] frame_of(input logic [7:0] w);
    return {1'b1, ^w, w, 1'b0};
  endfunction

  // ------------------------------------------------------------ monitor
  initial begin : monitor
    logic [10:0] got;
    logic [10:0] expf;
    logic        width_ok;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        got      = '0;
        width_ok = 1'b1;
        aborted  = 1'b0;
        for (int s = 0; s < FRAME_CLKS; s++) begin
          if (s > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (s % DIV == 0) got[s / DIV] = tx;
          else if (tx !== got[s / DIV]) width_ok = 1'b0;
        end
        if (!aborted) begin
          frames_seen++;
          check("bit_width", 32'(width_ok), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got 0x%03h, expected none", got);
          end else begin
            expf = exp_q.pop_front();
            check("frame", 32'(got), 32'(expf));
            $display("frame %0d: got 0x%03h expected 0x%03h", frames_seen, got, expf);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic push_word(input logic [7:0] w, input logic [10:0] f);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got ready=0, expected ready=1 within 2000 clk");
    end else begin
      data  = w;
      valid = 1'b1;
      exp_q.push_back(f);
      $display("push 0x%02h", w);
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: got no end of run, expected finish within 30000 clk");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin : main
    int lat;
    int bcnt;
    int idx;
    int accepted_before_drop;
    int max_level;
    int guard;
    int f0;
    logic dropped;
    logic [4:0] prev_level;

    // 1: reset for 10 clocks, then release.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_line", 32'(tx), 32'd1);
      check("rst_ready", 32'(ready), 32'd0);
    end
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(ready), 32'd1);
    check("rel_line", 32'(tx), 32'd1);
    check("rel_level", 32'(level), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // 2: single word 0xA5, latency and busy length.
    data  = 8'hA5;
    valid = 1'b1;
    exp_q.push_back(11'h54A);
    $display("push 0xa5");
    @(negedge clk);                 // first negedge after handshake edge N
    valid = 1'b0;
    lat   = -1;
    bcnt  = 0;
    for (int n = 1; n < 200; n++) begin
      if (tx === 1'b0 && lat < 0) lat = n - 1;
      if (busy) bcnt++;
      else if (bcnt > 0) break;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'd2);
    check("busy_len", 32'(bcnt), 32'(FRAME_CLKS));
    drain("single");

    // 3: stream 0x00..0x20 with valid held high.
    busy_first           = -1;
    idx                  = 0;
    accepted_before_drop = 0;
    max_level            = 0;
    guard                = 0;
    dropped              = 1'b0;
    prev_level           = level;
    while (idx < 33 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (int'(level) > max_level) max_level = int'(level);
      if (level != prev_level) check("ready_vs_level", 32'(ready), 32'(level < 5'd16));
      prev_level = level;
      data  = idx[7:0];
      valid = 1'b1;
      if (ready) begin
        exp_q.push_back(frame_of(idx[7:0]));
        $display("push 0x%02h", idx[7:0]);
        idx++;
        if (!dropped) accepted_before_drop++;
      end else begin
        dropped = 1'b1;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    check("stream_all_sent", 32'(idx), 32'd33);
    check("accepted_before_full", 32'(accepted_before_drop), 32'd17);
    check("level_peak", 32'(max_level), 32'd16);
    drain("stream");
    check("busy_span_zero_gap", 32'(busy_last - busy_first + 1), 32'(33 * FRAME_CLKS));

    // 4: directed parity corner words.
    push_word(8'hFF, 11'h5FE);
    push_word(8'h01, 11'h602);
    push_word(8'h80, 11'h700);
    push_word(8'h00, 11'h400);
    drain("directed");

    // 5: reset in the data bits of the 2nd of 3 queued words.
    f0 = frames_seen;
    push_word(8'h01, 11'h602);
    push_word(8'h80, 11'h700);
    push_word(8'hFF, 11'h5FE);
    guard = 0;
    while (frames_seen == f0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("first_of_three_done", 32'(frames_seen - f0), 32'd1);
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_line", 32'(tx), 32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", 32'(ready), 32'd1);
    f0 = frames_seen;
    push_word(8'h3C, 11'h478);
    drain("after_reset");
    check("after_reset_frames", 32'(frames_seen - f0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
